// File: rtl/code_mem_pkg.sv
// Shared types and defaults for the code RAM loader.
// CODE_RAM_CHECKSUM_EN adds the CHECK state used for checksum verification.
package code_mem_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 18;
  localparam int unsigned DEF_WORD_SIZE = 18;
  localparam int unsigned DEF_MEM_SIZE  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
`ifdef CODE_RAM_CHECKSUM_EN
    ST_CHECK = 3'd2,
`endif
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // Index width of a memory with n words, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // States in which the load stream is accepted.
  function automatic logic is_load_phase(input state_e s);
`ifdef CODE_RAM_CHECKSUM_EN
    return (s == ST_LOAD) || (s == ST_CHECK);
`else
    return (s == ST_LOAD);
`endif
  endfunction

endpackage

// File: rtl/code_mem_array.sv
// Code storage: one synchronous read port (0 beyond MEM_SIZE) and one write port.
// Reads return the pre-write content when both hit the same word in one cycle.
module code_mem_array
  import code_mem_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
  parameter int unsigned IDX_W     = idx_width(MEM_SIZE)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_SIZE-1:0] wr_data
);

  localparam int unsigned AW1 = ADDR_SIZE + 1;
  localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_SIZE);

  logic [WORD_SIZE-1:0] mem_q [MEM_SIZE];
  logic [WORD_SIZE-1:0] rd_data_d;
  logic [WORD_SIZE-1:0] rd_data_q;

  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < MEM_LIMIT) begin
      rd_data_d = mem_q[rd_addr[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is deliberately not reset so a reset mid-load keeps written words.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/code_ram_loader.sv
// Program loader for a processor code RAM: streams words in, then releases the processor.
// CODE_RAM_CHECKSUM_EN: a trailing checksum word must match the sum of the loaded words.
module code_ram_loader
  import code_mem_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] dout,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 processor_reset,
  output logic                 loading,
  output logic [ADDR_SIZE-1:0] load_count,
  output logic                 load_error
);

  localparam int unsigned IDX_W = idx_width(MEM_SIZE);
  localparam int unsigned AW1   = ADDR_SIZE + 1;
  localparam logic [AW1-1:0] MEM_LIMIT = AW1'(MEM_SIZE);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] load_count_q, load_count_d;
  logic                 load_error_q, load_error_d;
  logic                 processor_reset_q, processor_reset_d;
  logic                 load_ready_q, load_ready_d;
  logic                 loading_q, loading_d;
  logic                 mem_we;
  logic                 xfer;
  logic                 mem_full;
`ifdef CODE_RAM_CHECKSUM_EN
  logic [WORD_SIZE-1:0] csum_q, csum_d;
`endif

  assign xfer     = load_valid && load_ready_q;
  assign mem_full = ({1'b0, load_count_q} == MEM_LIMIT);

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    load_error_d = load_error_q;
    mem_we       = 1'b0;
`ifdef CODE_RAM_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    // A start pulse wins over any transfer in the same cycle.
    if (load_start) begin
      state_d      = ST_LOAD;
      load_count_d = '0;
      load_error_d = 1'b0;
`ifdef CODE_RAM_CHECKSUM_EN
      csum_d       = '0;
`endif
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (xfer) begin
            if (mem_full) begin
              load_error_d = 1'b1;
              state_d      = ST_ERROR;
            end else begin
              mem_we       = 1'b1;
              load_count_d = load_count_q + ADDR_SIZE'(1);
`ifdef CODE_RAM_CHECKSUM_EN
              csum_d       = csum_q + load_data;
              if (load_last) state_d = ST_CHECK;
`else
              if (load_last) state_d = ST_RUN;
`endif
            end
          end
        end
`ifdef CODE_RAM_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            if (load_data == csum_q) begin
              state_d = ST_RUN;
            end else begin
              load_error_d = 1'b1;
              state_d      = ST_ERROR;
            end
          end
        end
`endif
        default: ;
      endcase
    end
    processor_reset_d = (state_d != ST_RUN);
    load_ready_d      = is_load_phase(state_d);
    loading_d         = is_load_phase(state_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      load_count_q      <= '0;
      load_error_q      <= 1'b0;
      processor_reset_q <= 1'b1;
      load_ready_q      <= 1'b0;
      loading_q         <= 1'b0;
`ifdef CODE_RAM_CHECKSUM_EN
      csum_q            <= '0;
`endif
    end else begin
      state_q           <= state_d;
      load_count_q      <= load_count_d;
      load_error_q      <= load_error_d;
      processor_reset_q <= processor_reset_d;
      load_ready_q      <= load_ready_d;
      loading_q         <= loading_d;
`ifdef CODE_RAM_CHECKSUM_EN
      csum_q            <= csum_d;
`endif
    end
  end

  code_mem_array #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE),
    .MEM_SIZE (MEM_SIZE),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .rd_addr(addr),
    .rd_data(dout),
    .wr_en  (mem_we),
    .wr_idx (load_count_q[IDX_W-1:0]),
    .wr_data(load_data)
  );

  assign processor_reset = processor_reset_q;
  assign load_ready      = load_ready_q;
  assign loading         = loading_q;
  assign load_count      = load_count_q;
  assign load_error      = load_error_q;

endmodule

// File: tb/tb_code_ram_loader.sv
// Bench for code_ram_loader (MEM_SIZE = 4): directed loads against a word-level model.
// Checksum scenarios run only when CODE_RAM_CHECKSUM_EN is defined.
module tb_code_ram_loader;

  localparam int AS = 18;
  localparam int WS = 18;
  localparam int MS = 4;
`ifdef CODE_RAM_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CHECK = 2;
  localparam int P_RUN   = 3;
  localparam int P_ERROR = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AS-1:0] addr;
  logic [WS-1:0] dout;
  logic          load_start;
  logic          load_valid;
  logic [WS-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          processor_reset;
  logic          loading;
  logic [AS-1:0] load_count;
  logic          load_error;

  int n_checks = 0;
  int n_errors = 0;

  code_ram_loader #(.ADDR_SIZE(AS), .WORD_SIZE(WS), .MEM_SIZE(MS)) dut (
    .clock(clock), .reset(reset), .addr(addr), .dout(dout),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .processor_reset(processor_reset), .loading(loading),
    .load_count(load_count), .load_error(load_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: phase, word count, running sum, stored words.
  int            m_phase;
  int            m_count;
  logic          m_err;
  logic [WS-1:0] m_sum;
  logic [WS-1:0] m_dout;
  logic          m_dout_ok;
  logic [WS-1:0] m_mem [MS];
  bit            m_written [MS];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase   <= P_IDLE;
      m_count   <= 0;
      m_err     <= 1'b0;
      m_sum     <= '0;
      m_dout    <= '0;
      m_dout_ok <= 1'b1;
    end else begin
      if (int'(addr) < MS) begin
        m_dout    <= m_mem[int'(addr)];
        m_dout_ok <= m_written[int'(addr)];
      end else begin
        m_dout    <= '0;
        m_dout_ok <= 1'b1;
      end
      if (load_start) begin
        m_phase <= P_LOAD;
        m_count <= 0;
        m_err   <= 1'b0;
        m_sum   <= '0;
      end else if (load_valid && m_phase == P_LOAD) begin
        if (m_count == MS) begin
          m_err   <= 1'b1;
          m_phase <= P_ERROR;
        end else begin
          m_mem[m_count]     <= load_data;
          m_written[m_count] <= 1'b1;
          m_count            <= m_count + 1;
          m_sum              <= WS'(m_sum + load_data);
          if (load_last) m_phase <= CHK_EN ? P_CHECK : P_RUN;
        end
      end else if (load_valid && m_phase == P_CHECK) begin
        if (load_data == m_sum) begin
          m_phase <= P_RUN;
        end else begin
          m_err   <= 1'b1;
          m_phase <= P_ERROR;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clock) begin
    chk("model_processor_reset", 32'(processor_reset), 32'(m_phase != P_RUN));
    chk("model_load_ready", 32'(load_ready), 32'(m_phase == P_LOAD || m_phase == P_CHECK));
    chk("model_loading", 32'(loading), 32'(m_phase == P_LOAD || m_phase == P_CHECK));
    chk("model_load_count", 32'(load_count), 32'(m_count));
    chk("model_load_error", 32'(load_error), 32'(m_err));
    if (m_dout_ok) chk("model_dout", 32'(dout), 32'(m_dout));
  end

  task automatic step(input logic s, input logic v, input logic [WS-1:0] d,
                      input logic l, input logic [AS-1:0] a);
    @(negedge clock);
    load_start = s;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    addr       = a;
  endtask

  task automatic read_back(input string tag, input logic [WS-1:0] e0, input logic [WS-1:0] e1,
                           input logic [WS-1:0] e2, input logic [WS-1:0] e3);
    logic [WS-1:0] exp_w [5];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3; exp_w[4] = '0;
    for (int i = 0; i <= 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, AS'(i < 5 ? i : 0));
      if (i > 0) chk($sformatf("%s_mem%0d", tag, i - 1), 32'(dout), 32'(exp_w[i-1]));
    end
  endtask

  initial begin
    reset = 1'b0; addr = '0; load_start = 1'b0; load_valid = 1'b0;
    load_data = '0; load_last = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_processor_reset", 32'(processor_reset), 32'h1);
    chk("rst_load_ready", 32'(load_ready), 32'h0);
    chk("rst_loading", 32'(loading), 32'h0);
    chk("rst_load_count", 32'(load_count), 32'h0);
    chk("rst_load_error", 32'(load_error), 32'h0);
    reset = 1'b1;

    // Four-word load, last on the fourth.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00001, 1'b0, '0);
    chk("s1_ready_after_start", 32'(load_ready), 32'h1);
    step(1'b0, 1'b1, 18'h00002, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00003, 1'b0, '0);
    step(1'b0, 1'b1, 18'h3FFFF, 1'b1, '0);
    chk("s1_count_before_last", 32'(load_count), 32'd3);
    chk("s1_hold_before_last", 32'(processor_reset), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, AS'(3));
    if (CHK_EN) begin
      chk("s1_chk_loading", 32'(loading), 32'h1);
      step(1'b0, 1'b1, 18'h00005, 1'b0, AS'(3));
    end
    chk("s1_count", 32'(load_count), 32'd4);
    chk("s1_release", 32'(processor_reset), CHK_EN ? 32'h0 : 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("s1_dout_addr3", 32'(dout), 32'h3FFFF);

    // Restart from RUN, read-before-write, stall, overflow.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00010, 1'b0, '0);
    chk("s2_restart_hold", 32'(processor_reset), 32'h1);
    chk("s2_restart_count", 32'(load_count), 32'h0);
    chk("s2_restart_ready", 32'(load_ready), 32'h1);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("s2_rbw_old_word", 32'(dout), 32'h00001);
    step(1'b0, 1'b0, '0, 1'b1, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00020, 1'b0, '0);
    chk("s2_stall_count", 32'(load_count), 32'd1);
    chk("s2_stall_loading", 32'(loading), 32'h1);
    step(1'b0, 1'b1, 18'h00030, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00040, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00050, 1'b0, '0);
    step(1'b0, 1'b1, 18'h00077, 1'b1, AS'(1));
    chk("s2_overflow_error", 32'(load_error), 32'h1);
    chk("s2_overflow_hold", 32'(processor_reset), 32'h1);
    chk("s2_overflow_count", 32'(load_count), 32'd4);
    read_back("s2", 18'h10, 18'h20, 18'h30, 18'h40);

    // Restart coinciding with a transfer, then reset mid-load.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b1, 18'h000A1, 1'b0, '0);
    step(1'b1, 1'b1, 18'h000EE, 1'b1, '0);
    step(1'b0, 1'b1, 18'h000A1, 1'b0, '0);
    chk("s3_restart_count", 32'(load_count), 32'h0);
    chk("s3_restart_error", 32'(load_error), 32'h0);
    step(1'b0, 1'b1, 18'h000A2, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("s3_count_two", 32'(load_count), 32'd2);
    #1 reset = 1'b0;
    #1;
    chk("s3_rst_count", 32'(load_count), 32'h0);
    chk("s3_rst_hold", 32'(processor_reset), 32'h1);
    chk("s3_rst_ready", 32'(load_ready), 32'h0);
    chk("s3_rst_loading", 32'(loading), 32'h0);
    @(negedge clock);
    #1 reset = 1'b1;
    read_back("s3", 18'hA1, 18'hA2, 18'h30, 18'h40);

    if (CHK_EN) begin
      step(1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 18'h00010, 1'b0, '0);
      step(1'b0, 1'b1, 18'h00020, 1'b1, '0);
      step(1'b0, 1'b1, 18'h00030, 1'b0, '0);
      chk("s4_check_loading", 32'(loading), 32'h1);
      chk("s4_check_count", 32'(load_count), 32'd2);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      chk("s4_good_release", 32'(processor_reset), 32'h0);
      chk("s4_good_count", 32'(load_count), 32'd2);
      step(1'b1, 1'b0, '0, 1'b0, '0);
      step(1'b0, 1'b1, 18'h00010, 1'b0, '0);
      step(1'b0, 1'b1, 18'h00020, 1'b1, '0);
      step(1'b0, 1'b1, 18'h00031, 1'b0, '0);
      step(1'b0, 1'b0, '0, 1'b0, '0);
      chk("s4_bad_error", 32'(load_error), 32'h1);
      chk("s4_bad_hold", 32'(processor_reset), 32'h1);
      chk("s4_bad_ready", 32'(load_ready), 32'h0);
    end

    repeat (2) step(1'b0, 1'b0, '0, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
